mra_controller: RTL and testbench
=================================

Name: mra_controller

Overview:
- FSM controller for the 16-bit multiply-by-repeated-addition datapath: operand register A, down-counter B, product register P, adder, and B==0 comparator.
- Sequences operand loading from the shared data bus, clears P, then repeats P<=P+A / B<=B-1 until the comparator reports B==0.
- Provides a start/busy/done handshake, an abort, an iteration count and a watchdog error flag.

Parameters:
- WIDTH, 16, width of the iteration counter (matches datapath width)
- MAX_ITER, 16'hFFFF, add iterations allowed before the watchdog trips

Ports:
- clk  in  1  clock; all state changes on rising edge
- clr_n  in  1  synchronous active-low reset
- start  in  1  request a multiplication; sampled only in S_IDLE
- abort  in  1  synchronous abort; returns the FSM to S_IDLE
- eqz  in  1  datapath comparator output, 1 when the B register equals 0
- ldA  out  1  load the A register from the data bus
- ldB  out  1  load the B counter from the data bus
- clrP  out  1  clear the P register
- ldP  out  1  load P with P+A
- decB  out  1  decrement B
- busy  out  1  high in S_LOAD_A, S_LOAD_B, S_ADD
- done  out  1  one-cycle completion pulse
- err  out  1  watchdog tripped on the last operation; sticky until next start
- iter_cnt  out  WIDTH  adds performed in the current or last operation

Behaviour:
- Reset and polarity: the interface uses one clock, clk. Reset is clr_n: synchronous, active-low. While clr_n=0 at a rising edge: state<=S_IDLE, iter_cnt<=0, err<=0. All strobes, busy and done decode to 0 in S_IDLE.
- States: S_IDLE, S_LOAD_A, S_LOAD_B, S_ADD, S_DONE.
- S_IDLE: all strobes 0. If start=1, go to S_LOAD_A, clear iter_cnt and clear err.
- S_LOAD_A: ldA=1. The data bus must carry operand A in this cycle. Next state is S_LOAD_B.
- S_LOAD_B: ldB=1 and clrP=1 in the same cycle. The bus carries B. Next state is S_ADD.
- S_ADD (Mealy on eqz):
  - If eqz=1: no strobes; go to S_DONE.
  - Else if iter_cnt==MAX_ITER: no strobes; err<=1; go to S_DONE.
  - Else: ldP=1, decB=1, iter_cnt<=iter_cnt+1; stay in S_ADD.
- S_DONE: done=1 for exactly one cycle. Next state is S_IDLE.
- Latency: start sampled at edge t gives done high during cycle t+B+4 and exactly B ldP pulses. B=0 needs no special case: eqz is already 1 on the first S_ADD cycle, so done comes at t+4 with P=0.
- start is ignored outside S_IDLE. start held high through S_DONE launches a new operation from S_IDLE on the following edge.
- abort=1 at an edge in any state except S_IDLE: next state is S_IDLE with no done pulse. iter_cnt and err hold their values. Datapath register contents are then undefined to the requester.
- Priority at a single edge: clr_n=0 over abort, and abort over normal transitions.
- iter_cnt saturates at MAX_ITER and never wraps.
- err is set only by the watchdog and is cleared only by reset or by accepting start.
- Strobes are mutually consistent: ldA, ldB and ldP are never high together. clrP and ldP are never high together.

Decomposition:
- Shared package mra_pkg holds the state encoding localparams (3-bit binary: S_IDLE=0 … S_DONE=4) and the default WIDTH/MAX_ITER constants, reused by the datapath top and the bench.
- No sub-module is needed. The state register, next-state logic, output decode and iteration counter all sit in mra_controller.

Test Plan:
- A=7, B=5, start pulse at edge 0: exactly 5 ldP/decB pulses, done in cycle 9, P=35, iter_cnt=5, err=0.
- A=9, B=0: no ldP pulses, done in cycle 4, P=0, iter_cnt=0.
- A=16'h00FF, B=3: P=16'h02FD, done in cycle 7, busy high in cycles 1–6 only.
- MAX_ITER=8 override, eqz held 0: 8 adds, err=1, done pulses, iter_cnt=8. The next start clears err.
- Abort in the 3rd S_ADD cycle of A=4, B=6: no done, S_IDLE next, iter_cnt holds 2. A restart with B=2 completes correctly.
- clr_n=0 mid-S_ADD: the following cycle has all outputs 0, iter_cnt=0 and state S_IDLE. start asserted outside S_IDLE is ignored.

Source files
------------

// File: rtl/mra_pkg.sv
// Shared constants and state encoding for the multiply-by-repeated-addition
// controller, its datapath top and the bench.
package mra_pkg;

  localparam int unsigned MRA_WIDTH    = 16;
  localparam logic [15:0] MRA_MAX_ITER = 16'hFFFF;

  // 3-bit binary state encoding
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_ADD    = 3'd3,
    S_DONE   = 3'd4
  } mra_state_e;

endpackage

// File: rtl/mra_controller.sv
// Controller for the multiply-by-repeated-addition datapath: loads A and B
// from the shared bus, clears P, then repeats P<=P+A / B<=B-1 until B==0.
// Provides start/busy/done, abort, an iteration count and a watchdog flag.
module mra_controller
  import mra_pkg::*;
#(
  parameter int unsigned      WIDTH    = MRA_WIDTH,
  parameter logic [WIDTH-1:0] MAX_ITER = WIDTH'(MRA_MAX_ITER)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             abort,
  input  logic             eqz,
  output logic             ldA,
  output logic             ldB,
  output logic             clrP,
  output logic             ldP,
  output logic             decB,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] iter_cnt
);

  mra_state_e state_q, state_d;
  logic       accept;   // start taken in S_IDLE: clear count and err
  logic       inc_iter; // one add performed this cycle
  logic       wd_trip;  // watchdog limit reached

  // State register, iteration counter and sticky watchdog flag
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q  <= S_IDLE;
      iter_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        iter_cnt <= '0;
        err      <= 1'b0;
      end else begin
        if (inc_iter) iter_cnt <= iter_cnt + WIDTH'(1);
        if (wd_trip)  err      <= 1'b1;
      end
    end
  end

  // Next-state and strobe decode; abort suppresses every strobe and the
  // done pulse so an aborted cycle leaves iter_cnt and err untouched
  always_comb begin
    state_d  = state_q;
    ldA      = 1'b0;
    ldB      = 1'b0;
    clrP     = 1'b0;
    ldP      = 1'b0;
    decB     = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    inc_iter = 1'b0;
    wd_trip  = 1'b0;
    busy     = (state_q == S_LOAD_A) || (state_q == S_LOAD_B) || (state_q == S_ADD);

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            accept  = 1'b1;
            state_d = S_LOAD_A;
          end
        end
        S_LOAD_A: begin
          ldA     = 1'b1;
          state_d = S_LOAD_B;
        end
        S_LOAD_B: begin
          ldB     = 1'b1;
          clrP    = 1'b1;
          state_d = S_ADD;
        end
        S_ADD: begin
          if (eqz) begin
            state_d = S_DONE;
          end else if (iter_cnt == MAX_ITER) begin
            wd_trip = 1'b1;
            state_d = S_DONE;
          end else begin
            ldP      = 1'b1;
            decB     = 1'b1;
            inc_iter = 1'b1;
          end
        end
        S_DONE: begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mra_controller.sv
// Scoreboard bench for mra_controller with a behavioural A/B/P datapath.
module tb_mra_controller;
  import mra_pkg::*;

  typedef struct {
    logic [15:0] p;
    logic [15:0] iter;
    logic        err;
    int unsigned cyc;
    int unsigned nadd;
  } exp_t;

  logic clk = 1'b0;
  logic clr_n, start, abort, start2, abort2, eqz2;
  logic [15:0] bus;

  logic ldA1, ldB1, clrP1, ldP1, decB1, busy1, done1, err1, eqz1;
  logic [15:0] iter1;
  logic ldA2, ldB2, clrP2, ldP2, decB2, busy2, done2, err2;
  logic [15:0] iter2;

  logic [15:0] ra = '0, rb = '0, rp = '0;

  int unsigned cyc = 0;
  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  bit bw_en = 1'b0;
  int unsigned bw_lo, bw_hi;
  int unsigned nadd1 = 0;
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mra_controller dut1 (
    .clk(clk), .clr_n(clr_n), .start(start), .abort(abort), .eqz(eqz1),
    .ldA(ldA1), .ldB(ldB1), .clrP(clrP1), .ldP(ldP1), .decB(decB1),
    .busy(busy1), .done(done1), .err(err1), .iter_cnt(iter1)
  );

  mra_controller #(.WIDTH(16), .MAX_ITER(16'd8)) dut2 (
    .clk(clk), .clr_n(clr_n), .start(start2), .abort(abort2), .eqz(eqz2),
    .ldA(ldA2), .ldB(ldB2), .clrP(clrP2), .ldP(ldP2), .decB(decB2),
    .busy(busy2), .done(done2), .err(err2), .iter_cnt(iter2)
  );

  // Behavioural datapath driven by dut1 strobes
  always @(posedge clk) begin
    if (ldA1) ra <= bus;
    if (ldB1) rb <= bus;
    else if (decB1) rb <= rb - 16'd1;
    if (clrP1) rp <= '0;
    else if (ldP1) rp <= rp + ra;
  end
  assign eqz1 = (rb == 16'd0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor for dut1: strobe consistency every cycle, scoreboard on done
  always @(negedge clk) begin
    if (mon_en) begin
      chk("strobe_excl", {31'd0, (ldA1 & ldB1) | (ldA1 & ldP1) | (ldB1 & ldP1) | (clrP1 & ldP1)}, 32'd0);
      if (ldA1) nadd1 = 0;
      else if (ldP1 === 1'b1) nadd1++;
      if (done1 === 1'b1) begin
        if (q1.size() == 0) begin
          chk("unexpected_done1", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q1.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("product", {16'd0, rp}, {16'd0, e.p});
          chk("iter_cnt", {16'd0, iter1}, {16'd0, e.iter});
          chk("err", {31'd0, err1}, {31'd0, e.err});
          chk("add_pulses", nadd1, e.nadd);
        end
      end
      if (bw_en && cyc + 1 >= bw_lo && cyc <= bw_hi + 1)
        chk("busy_window", {31'd0, busy1}, {31'd0, (cyc >= bw_lo && cyc <= bw_hi)});
    end
  end

  // Monitor for the watchdog instance
  always @(negedge clk) begin
    if (mon_en && done2 === 1'b1) begin
      if (q2.size() == 0) begin
        chk("unexpected_done2", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("wd_done_cycle", cyc, e.cyc);
        chk("wd_iter_cnt", {16'd0, iter2}, {16'd0, e.iter});
        chk("wd_err", {31'd0, err2}, {31'd0, e.err});
      end
    end
  end

  // Start an operation on dut1; returns in the first S_ADD cycle
  task automatic launch1(input logic [15:0] a, input logic [15:0] b, input bit push);
    if (push) q1.push_back('{p: 16'(a * b), iter: b, err: 1'b0, cyc: cyc + 32'(b) + 4, nadd: 32'(b)});
    start = 1'b1;
    bus   = a;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    bus = b;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_q1", q1.size(), 32'd0);
    chk("drain_q2", q2.size(), 32'd0);
    q1.delete();
    q2.delete();
  endtask

  task automatic chk_quiet1(input string name);
    chk(name, {ldA1, ldB1, clrP1, ldP1, decB1, busy1, done1, err1}, 32'd0);
    chk({name, "_iter"}, {16'd0, iter1}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int unsigned t;
    clr_n = 1'b0; start = 1'b0; abort = 1'b0; bus = '0;
    start2 = 1'b0; abort2 = 1'b0; eqz2 = 1'b0;
    repeat (3) @(negedge clk);
    chk_quiet1("reset1");
    chk("reset2", {ldA2, ldB2, clrP2, ldP2, decB2, busy2, done2, err2}, 32'd0);
    clr_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // A=7, B=5
    launch1(16'd7, 16'd5, 1'b1);
    drain(40);
    @(negedge clk);

    // A=9, B=0
    launch1(16'd9, 16'd0, 1'b1);
    drain(40);
    @(negedge clk);

    // A=FF, B=3 with busy window cycles t+1..t+6
    t = cyc;
    bw_lo = t + 1;
    bw_hi = t + 6;
    bw_en = 1'b1;
    launch1(16'h00FF, 16'd3, 1'b1);
    drain(40);
    repeat (2) @(negedge clk);
    bw_en = 1'b0;

    // Watchdog instance, eqz held 0: 8 adds then err
    q2.push_back('{p: '0, iter: 16'd8, err: 1'b1, cyc: cyc + 12, nadd: 0});
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    drain(40);
    chk("wd_err_sticky", {31'd0, err2}, 32'd1);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("wd_err_cleared", {31'd0, err2}, 32'd0);
    chk("wd_iter_cleared", {16'd0, iter2}, 32'd0);
    abort2 = 1'b1;
    @(negedge clk);
    abort2 = 1'b0;
    chk("wd_abort_idle", {31'd0, busy2}, 32'd0);
    repeat (2) @(negedge clk);

    // Abort in 3rd S_ADD cycle of A=4, B=6
    launch1(16'd4, 16'd6, 1'b0);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy1}, 32'd0);
    chk("abort_done", {31'd0, done1}, 32'd0);
    chk("abort_iter", {16'd0, iter1}, 32'd2);
    chk("abort_err", {31'd0, err1}, 32'd0);
    repeat (4) @(negedge clk);
    launch1(16'd4, 16'd2, 1'b1);
    drain(40);
    @(negedge clk);

    // Reset mid-S_ADD
    launch1(16'd3, 16'd4, 1'b0);
    @(negedge clk);
    clr_n = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    chk_quiet1("midop_reset");
    repeat (2) @(negedge clk);

    // start asserted during S_ADD must be ignored
    launch1(16'd5, 16'd3, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain(40);
    repeat (3) @(negedge clk);
    chk("no_relaunch", {31'd0, busy1}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
